serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial unsigned subtractor, LSB first: diff = a - b, one bit per clock.
//   Inverse-direction companion to the team's combinational half/full adders.
//   Sits beside them in the arithmetic library.
//   Trades latency (WIDTH cycles) for one full-subtractor cell plus one borrow flop.
//   Start/done handshake lets a controller or testbench sequence operands.
// PARAMETERS
//   WIDTH   4   operand/result width in bits; legal range >= 1
// PORTS
//   clk         in   1      single clock; all state changes on rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   start       in   1      request; sampled only in IDLE
//   a           in   WIDTH  minuend; captured on the accepting edge
//   b           in   WIDTH  subtrahend; captured on the accepting edge
//   busy        out  1      high while an operation is in progress (SHIFT or DONE)
//   done        out  1      one-cycle pulse: result registers just updated
//   diff        out  WIDTH  result register, (a - b) mod 2^WIDTH
//   borrow_out  out  1      final borrow; 1 iff a < b (unsigned)
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous, any state):
//     - state=IDLE; busy=0, done=0, diff=0, borrow_out=0
//     - internal shift regs, borrow flop and bit counter all cleared
//     - takes effect immediately, no clock needed
//     - any operation in flight is discarded
//   States:
//     - IDLE:
//       - start=1 at an edge -> capture a,b into shift regs, borrow=0, cnt=0 -> SHIFT
//       - start=0 -> stay in IDLE
//     - SHIFT: each edge processes bit a_sr[0], b_sr[0] with borrow br:
//       - d = a0 ^ b0 ^ br
//       - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
//       - d is shifted into the MSB of an internal result shift reg
//       - a_sr, b_sr shift right; cnt++
//       - on the edge with cnt==WIDTH-1: load diff from the completed shift reg,
//         load borrow_out from br', then -> DONE
//     - DONE: done=1 for exactly this one cycle; next edge -> IDLE
//   Timing:
//     - accepting edge = E
//     - bits processed on edges E+1 .. E+WIDTH
//     - diff, borrow_out and done are valid after edge E+WIDTH
//     - busy is high from after E until after E+WIDTH+1
//     - next start can be accepted at the earliest on edge E+WIDTH+2
//   Output holding:
//     - diff and borrow_out hold their value until the next completion or reset
//     - they never show partial results during SHIFT
//   Other rules:
//     - start while busy (SHIFT or DONE) is ignored; a and b may change freely while busy
//     - a held-high start re-triggers on every IDLE edge, i.e. back-to-back
//       operations with one IDLE cycle between them
//     - WIDTH=1: a single SHIFT edge, then DONE
//     - counter width is $clog2(WIDTH)+1; there is no wrap hazard
//   Arithmetic: unsigned two's-complement wrap
//     - diff = (a + ~b + 1) mod 2^WIDTH
//     - borrow_out = ~carry of that sum
// TESTING (WIDTH=4 unless stated)
//   1) a=9, b=3, single start pulse
//      -> done exactly 4 edges after accept; diff=6, borrow_out=0; busy drops one cycle later
//   2) a=3, b=9 -> diff=10, borrow_out=1.  a=0, b=15 -> diff=1, borrow_out=1.
//      a=15, b=15 -> diff=0, borrow_out=0
//   3) Exhaustive: all 256 (a,b) pairs, sequenced with the handshake
//      -> every result matches reference model {borrow,diff} = {a<b, (a-b)&15};
//      done pulses exactly 256 times
//   4) Start held high and a,b changed during SHIFT
//      -> mid-op start ignored; result uses captured operands;
//      new op accepted on the first IDLE edge
//   5) Reset asserted asynchronously mid-SHIFT (after 2 bits)
//      -> busy, done, diff, borrow_out = 0 immediately, without a clock edge;
//      after release, a=5, b=2 -> diff=3, borrow_out=0
//   6) WIDTH=1 and WIDTH=8 builds
//      -> 1-1=0/0, 0-1=1/1; 200-55=145/0, 55-200=111/1;
//      done latency equals WIDTH in each build

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first: diff = a - b, one bit per clock.
// One full-subtractor cell plus a borrow flop; start/done handshake for sequencing.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             br;
  logic             d;
  logic             br_next;
  logic [CW-1:0]    cnt;

  // Full-subtractor cell; the new difference bit enters the result MSB so the
  // LSB-first stream lands in place after WIDTH shifts (works for WIDTH=1 too).
  always_comb begin
    d                 = a_sr[0] ^ b_sr[0] ^ br;
    br_next           = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    res_next          = res_sr >> 1;
    res_next[WIDTH-1] = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          br     <= br_next;
          cnt    <= cnt + CW'(1);
          // Visible outputs update only once the whole word is assembled.
          if (cnt == CW'(WIDTH - 1)) begin
            diff       <= res_next;
            borrow_out <= br_next;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
